// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with optional zero register,
// optional write-to-read bypass and a sequenced bulk-clear engine.
module regfile_param #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Aaddr,
  input  logic [ADDR_W-1:0] Baddr,
  input  logic [ADDR_W-1:0] Waddr,
  input  logic              writeEn,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              clearReq,
  output logic [DATA_W-1:0] Adata,
  output logic [DATA_W-1:0] Bdata,
  output logic              busy,
  output logic              wrDropped
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_idx_reg, clr_idx_next;
  logic              clr_en;
  logic              clr_last;
  logic              wr_zero;
  logic              wr_commit;
  logic              fwd_en;
  logic              wr_dropped_reg;
  logic [DATA_W-1:0] mem [DEPTH];

  assign clr_last  = (clr_idx_reg == ADDR_W'(DEPTH - 1));
  // Writes aimed at a hardwired zero register vanish quietly; they are not drops.
  assign wr_zero   = ZERO_REG && (Waddr == '0);
  assign wr_commit = writeEn && !busy && !wr_zero;
  assign fwd_en    = BYPASS && wr_commit;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg   <= IDLE;
      clr_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_idx_reg <= clr_idx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_idx_next = clr_idx_reg;
    case (state_reg)
      IDLE: begin
        if (clearReq) begin
          state_next   = CLEAR;
          clr_idx_next = '0;
        end
      end
      CLEAR: begin
        if (clr_last) begin
          state_next   = IDLE;
          clr_idx_next = '0;
        end else begin
          clr_idx_next = clr_idx_reg + 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        clr_idx_next = '0;
      end
    endcase
  end

  always_comb begin
    busy   = (state_reg == CLEAR);
    clr_en = (state_reg == CLEAR);
  end

  // Clear and write never coincide: writes are only accepted while not busy.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr_en) begin
      mem[clr_idx_reg] <= '0;
    end else if (wr_commit) begin
      mem[Waddr] <= WriteData;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_dropped_reg <= 1'b0;
    end else begin
      wr_dropped_reg <= writeEn && busy;
    end
  end

  assign wrDropped = wr_dropped_reg;

  always_comb begin
    Adata = mem[Aaddr];
    if (fwd_en && (Aaddr == Waddr)) Adata = WriteData;
    if (ZERO_REG && (Aaddr == '0)) Adata = '0;
  end

  always_comb begin
    Bdata = mem[Baddr];
    if (fwd_en && (Baddr == Waddr)) Bdata = WriteData;
    if (ZERO_REG && (Baddr == '0)) Bdata = '0;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: one plain instance and one with the
// zero register and bypass enabled, driven from shared stimulus.
module tb_regfile_param;

  logic        clk;
  logic        rst;
  logic [3:0]  aaddr, baddr, waddr;
  logic        we;
  logic [15:0] wdata;
  logic        clr;
  logic [15:0] a0, b0, a1, b1;
  logic        busy0, busy1, drop0, drop1;

  int errors;
  int checks;

  regfile_param #(.DATA_W(16), .DEPTH(16), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut0 (
    .Clock(clk), .Reset(rst), .Aaddr(aaddr), .Baddr(baddr), .Waddr(waddr),
    .writeEn(we), .WriteData(wdata), .clearReq(clr),
    .Adata(a0), .Bdata(b0), .busy(busy0), .wrDropped(drop0)
  );

  regfile_param #(.DATA_W(16), .DEPTH(16), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut1 (
    .Clock(clk), .Reset(rst), .Aaddr(aaddr), .Baddr(baddr), .Waddr(waddr),
    .writeEn(we), .WriteData(wdata), .clearReq(clr),
    .Adata(a1), .Bdata(b1), .busy(busy1), .wrDropped(drop1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Called 1 time unit after a rising edge; returns at the same phase.
  task automatic do_write(input logic [3:0] a, input logic [15:0] d);
    waddr = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; we = 1'b0; clr = 1'b0;
    aaddr = '0; baddr = '0; waddr = '0; wdata = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    checks++;
    if (drop0 !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", drop0); end
    for (int i = 0; i < 16; i++) begin
      aaddr = 4'(i);
      baddr = 4'(15 - i);
      #1;
      checks++;
      if (a0 !== 16'h0 || b0 !== 16'h0 || a1 !== 16'h0) begin
        errors++;
        $display("FAIL reset_read addr=%0d got a0=%h b0=%h a1=%h exp=0000", i, a0, b0, a1);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_fill;
    logic [15:0] ea1, eb1;
    for (int i = 0; i < 16; i++) do_write(4'(i), 16'(i + 16'h100));
    for (int i = 0; i < 16; i++) begin
      aaddr = 4'(i);
      baddr = 4'(15 - i);
      #1;
      ea1 = (i == 0) ? 16'h0 : 16'(i + 16'h100);
      eb1 = (i == 15) ? 16'h0 : 16'(16'h10F - i);
      checks++;
      if (a0 !== 16'(i + 16'h100) || b0 !== 16'(16'h10F - i)) begin
        errors++;
        $display("FAIL fill_plain i=%0d got a=%h b=%h exp a=%h b=%h", i, a0, b0,
                 16'(i + 16'h100), 16'(16'h10F - i));
      end
      checks++;
      if (a1 !== ea1 || b1 !== eb1) begin
        errors++;
        $display("FAIL fill_zreg i=%0d got a=%h b=%h exp a=%h b=%h", i, a1, b1, ea1, eb1);
      end
    end
    $display("test_fill done");
  endtask

  task automatic test_zero_reg;
    aaddr = 4'd0;
    waddr = 4'd0;
    wdata = 16'hBEEF;
    we    = 1'b1;
    #1;
    checks++;
    if (a1 !== 16'h0) begin errors++; $display("FAIL zreg_nobypass got=%h exp=0000", a1); end
    checks++;
    if (a0 !== 16'h0100) begin errors++; $display("FAIL zreg_plain_pre got=%h exp=0100", a0); end
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    checks++;
    if (a0 !== 16'hBEEF) begin errors++; $display("FAIL zreg_plain_post got=%h exp=beef", a0); end
    checks++;
    if (a1 !== 16'h0) begin errors++; $display("FAIL zreg_post got=%h exp=0000", a1); end
    checks++;
    if (drop1 !== 1'b0 || drop0 !== 1'b0) begin
      errors++; $display("FAIL zreg_drop got=%b%b exp=00", drop0, drop1);
    end
    $display("test_zero_reg done");
  endtask

  task automatic test_bypass;
    do_write(4'd5, 16'h1111);
    aaddr = 4'd5;
    baddr = 4'd5;
    waddr = 4'd5;
    wdata = 16'h2222;
    we    = 1'b1;
    #1;
    checks++;
    if (a1 !== 16'h2222 || b1 !== 16'h2222) begin
      errors++; $display("FAIL bypass_fwd got a=%h b=%h exp 2222", a1, b1);
    end
    checks++;
    if (a0 !== 16'h1111) begin errors++; $display("FAIL bypass_off_pre got=%h exp=1111", a0); end
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    checks++;
    if (a0 !== 16'h2222 || a1 !== 16'h2222) begin
      errors++; $display("FAIL bypass_post got a0=%h a1=%h exp 2222", a0, a1);
    end
    $display("test_bypass done");
  endtask

  task automatic test_clear;
    logic [15:0] ea;
    for (int i = 0; i < 16; i++) do_write(4'(i), 16'hFFFF);
    aaddr = 4'd3;
    clr   = 1'b1;
    // Iteration c samples just after edge N+c, where edge N takes the request.
    for (int c = 0; c <= 16; c++) begin
      @(posedge clk);
      #1;
      ea = (c >= 4) ? 16'h0 : 16'hFFFF;
      checks++;
      if (busy0 !== (c < 16) || busy1 !== (c < 16)) begin
        errors++; $display("FAIL clear_busy c=%0d got=%b%b exp=%b", c, busy0, busy1, c < 16);
      end
      checks++;
      if (a0 !== ea) begin errors++; $display("FAIL clear_entry3 c=%0d got=%h exp=%h", c, a0, ea); end
      checks++;
      if (drop0 !== (c == 6) || drop1 !== (c == 6)) begin
        errors++; $display("FAIL clear_drop c=%0d got=%b%b exp=%b", c, drop0, drop1, c == 6);
      end
      clr   = (c == 5);
      we    = (c == 5);
      waddr = 4'd9;
      wdata = 16'h00AA;
    end
    clr = 1'b0;
    we  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      aaddr = 4'(i);
      baddr = 4'(i);
      #1;
      checks++;
      if (a0 !== 16'h0 || b1 !== 16'h0) begin
        errors++; $display("FAIL clear_final addr=%0d got a0=%h b1=%h exp=0000", i, a0, b1);
      end
    end
    $display("test_clear done");
  endtask

  task automatic test_reset_mid_clear;
    do_write(4'd2, 16'h1234);
    aaddr = 4'd12;
    baddr = 4'd2;
    waddr = 4'd12;
    wdata = 16'h5678;
    we    = 1'b1;
    clr   = 1'b1;
    @(posedge clk);
    #1;
    we  = 1'b0;
    clr = 1'b0;
    checks++;
    if (a0 !== 16'h5678 || busy0 !== 1'b1) begin
      errors++; $display("FAIL clear_with_write got a0=%h busy=%b exp 5678/1", a0, busy0);
    end
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (a0 !== 16'h5678 || b0 !== 16'h0) begin
      errors++; $display("FAIL midclear_pre got a0=%h b0=%h exp 5678/0000", a0, b0);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL midclear_busy got=%b%b exp=00", busy0, busy1);
    end
    checks++;
    if (a0 !== 16'h0 || a1 !== 16'h0) begin
      errors++; $display("FAIL midclear_entries got a0=%h a1=%h exp=0000", a0, a1);
    end
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_write(4'd12, 16'h4321);
    checks++;
    if (a0 !== 16'h4321 || a1 !== 16'h4321 || busy0 !== 1'b0) begin
      errors++; $display("FAIL post_reset_write got a0=%h a1=%h busy=%b exp 4321/0", a0, a1, busy0);
    end
    $display("test_reset_mid_clear done");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_fill();
    test_zero_reg();
    test_bypass();
    test_clear();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
